fifo_uart_tx: RTL
=================

# fifo_uart_tx

Serial transmit stage directly downstream of the 8-deep byte FIFO buffer. It pops bytes from the FIFO's read side whenever the FIFO is non-empty and transmission is enabled. Each byte goes out as an asynchronous serial frame: start bit, 8 data bits LSB first, optional parity, stop bit(s). It is the consumer that turns buffered parallel data into a line-level bitstream.

## Interface
Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be ≥ 2.
- STOP_BITS, 1: number of stop bits; legal values are 1 or 2.

Ports:
- clk  input  1  single clock; every register is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_en  input  1  permits starting new frames; a frame already in progress always completes.
- stack_empty  input  1  FIFO empty flag.
- Data_out  input  8  FIFO read data; registered in the FIFO, valid the cycle after a read request.
- read_from_stack  output  1  FIFO pop request; single-cycle pulse.
- tx  output  1  serial line, idles high; registered output.
- busy  output  1  high from FETCH through the last stop-bit cycle.
- frame_done  output  1  one-cycle pulse on the final cycle of the last stop bit.

## Operation
- Reset values: tx=1, busy=0, read_from_stack=0, frame_done=0, state=IDLE, baud counter=0, bit counter=0, shift register=0.
- States and transitions:
  - IDLE: go to FETCH if tx_en && !stack_empty; otherwise stay.
  - FETCH: read_from_stack=1 for exactly one cycle. Always go to LOAD.
  - LOAD: capture Data_out into the 8-bit shift register. Go to START.
  - START: tx=0 for CLKS_PER_BIT cycles. Then go to DATA.
  - DATA: tx=shift[0]. Shift right every CLKS_PER_BIT cycles. After 8 bits go to PARITY if that feature is compiled in, otherwise to STOP.
  - PARITY: tx=even parity of the captured byte for CLKS_PER_BIT cycles. Then go to STOP.
  - STOP: tx=1 for STOP_BITS×CLKS_PER_BIT cycles. frame_done pulses on the last cycle. Then go to FETCH if tx_en && !stack_empty, otherwise to IDLE.
- Pop rule: read_from_stack is asserted only when stack_empty was low on the deciding edge. The block never pops an empty FIFO.
- The baud counter has width $clog2(CLKS_PER_BIT). It clears on entry to START and on every bit boundary. It wraps at CLKS_PER_BIT-1; it does not run freely.
- The bit counter is 3 bits and counts 0..7 within DATA.
- tx_en falling mid-frame has no effect on the current frame. It only blocks the next FETCH.
- stack_empty changing mid-frame is ignored. It is sampled only in IDLE and on the last STOP cycle.
- rst asserted mid-frame: on the next edge tx=1 and state=IDLE. The frame is truncated, with no pop and no frame_done.

## Timing
- Edge e0 samples tx_en && !stack_empty in IDLE.
- read_from_stack is high in the cycle after e0.
- Data_out is captured at e2.
- tx falls at e3, so first-edge-to-start-bit latency is 3 cycles.
- Frame length in cycles: (1 + 8 + P + STOP_BITS)×CLKS_PER_BIT, where P=1 with parity and 0 without.
- Back-to-back frames: 2 idle-high cycles (FETCH, LOAD) between the last stop cycle and the next start bit.
- busy is high from the FETCH cycle until the last stop-bit cycle, inclusive.
- Throughput: one byte per frame length + 2 cycles.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state exists and one even-parity bit follows the data. Parity is the XOR of the 8 data bits, so tx is 1 when the byte has an odd number of ones.
- UART_TX_PARITY_EN undefined: the PARITY state and its logic are absent, and DATA goes directly to STOP.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, FETCH, LOAD, START, DATA, PARITY, STOP);
  - the data width constant 8;
  - a function computing the baud-counter width from CLKS_PER_BIT.
- One sub-module, uart_baud_cnt: a clearable counter that emits a one-cycle bit_tick when it reaches CLKS_PER_BIT-1.
- The FSM, shift register and parity stay in fifo_uart_tx.

## Test plan
All scenarios use CLKS_PER_BIT=4 and STOP_BITS=1.
- Reset: assert rst for 2 cycles with the FIFO non-empty -> tx=1, busy=0, read_from_stack=0 throughout. First pop occurs 1 cycle after rst falls.
- Single byte 0xA5, no parity: tx sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each held 4 cycles. Frame is 40 cycles. Exactly one read_from_stack pulse, and frame_done at cycle 40 of the frame.
- Parity build, byte 0x07 -> parity bit 1, 44-cycle frame. Byte 0x03 -> parity bit 0.
- Three bytes 0x01, 0x80, 0xFF pre-loaded -> three frames, each separated by exactly 2 idle-high cycles. 3 pops, and no pop once stack_empty=1.
- tx_en dropped at cycle 10 of the first of two queued frames -> the first frame completes, no second pop, tx stays 1. Raising tx_en resumes with FETCH on the next cycle.
- rst pulsed at cycle 20 of a frame -> tx=1 on the next edge, state IDLE, no frame_done. The next frame pops a fresh byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART transmit types: FSM state encoding, data width, baud-counter sizing.
// Imported by fifo_uart_tx and uart_baud_cnt.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Counter must hold 0..clks_per_bit-1; never narrower than one bit.
  function automatic int baud_cnt_w(input int clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Clearable bit-period counter: wraps at CLKS_PER_BIT-1 and flags that cycle with bit_tick.
// No latency beyond the count itself; clr holds the count at zero.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);

  localparam int CW = baud_cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter; tx falls 3 cycles after the deciding edge, 2 idle cycles between frames.
// Pops only a non-empty FIFO while tx_en is high; UART_TX_PARITY_EN adds an even-parity bit.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              stack_empty,
  input  logic [DATA_W-1:0] Data_out,
  output logic              read_from_stack,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  tx_state_t         state;
  tx_state_t         state_n;
  logic [DATA_W-1:0] shift;
  logic [2:0]        bit_cnt;
  logic              bit_tick;
  logic              baud_clr;
  logic              can_fetch;
  logic              data_last;
  logic              stop_last;
  logic              tx_n;
`ifdef UART_TX_PARITY_EN
  logic              parity;
`endif

  // Counter sits at zero until START so the start bit gets a full period.
  assign baud_clr  = (state == IDLE) || (state == FETCH) || (state == LOAD);
  assign can_fetch = tx_en && !stack_empty;
  assign data_last = bit_tick && (bit_cnt == 3'd7);
  assign stop_last = bit_tick && (bit_cnt == 3'(STOP_BITS - 1));

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (baud_clr),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        if (can_fetch) state_n = FETCH;
      end
      FETCH: state_n = LOAD;
      LOAD:  state_n = START;
      START: begin
        tx_n = 1'b0;
        if (bit_tick) state_n = DATA;
      end
      DATA: begin
        tx_n = shift[0];
`ifdef UART_TX_PARITY_EN
        if (data_last) state_n = PARITY;
`else
        if (data_last) state_n = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_n = parity;
        if (bit_tick) state_n = STOP;
      end
`endif
      STOP: begin
        if (stop_last) state_n = can_fetch ? FETCH : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Bit counter indexes data bits in DATA and stop bits in STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= 3'd0;
    end else if (state != state_n) begin
      bit_cnt <= 3'd0;
    end else if (((state == DATA) || (state == STOP)) && bit_tick) begin
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift <= '0;
    end else if (state == LOAD) begin
      shift <= Data_out;
    end else if ((state == DATA) && bit_tick) begin
      shift <= {1'b0, shift[DATA_W-1:1]};
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (state == LOAD) begin
      parity <= ^Data_out;
    end
  end
`endif

  // Outputs are registered, so the line trails the state register by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx              <= 1'b1;
      busy            <= 1'b0;
      read_from_stack <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      tx              <= tx_n;
      busy            <= (state_n != IDLE) || (state == STOP);
      read_from_stack <= (state_n == FETCH);
      frame_done      <= (state == STOP) && stop_last;
    end
  end

endmodule
